// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, ALU selects,
// FSM state encoding and instruction field positions.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_LDI = 3'b011;
  localparam logic [2:0] OP_OUT = 3'b100;

  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b01;
  localparam logic [1:0] SEL_NOT = 2'b10;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 11;
  localparam int RS_MSB  = 10;
  localparam int RS_LSB  = 9;
  localparam int RT_MSB  = 8;
  localparam int RT_LSB  = 7;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_EMIT = 2'b10
  } state_t;

  function automatic logic [1:0] op_to_sel(input logic [2:0] op);
    case (op)
      OP_SUB:  return SEL_SUB;
      OP_NOT:  return SEL_NOT;
      default: return SEL_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Small register file: two combinational read ports, one synchronous write
// port, synchronous active-low clear of every entry.
module alu_regfile #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_op_sequencer.sv
// Decodes 16-bit instructions, sequences one-cycle ALU operations against a
// 4-entry register file and emits register values over a valid/ready port.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_select,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              zero_flag,
  output logic              illegal
);

  localparam int ADDR_W = $clog2(NREGS);

  state_t            state_reg;
  logic [2:0]        op_reg;
  logic [ADDR_W-1:0] rd_reg, rs_reg, rt_reg;
  logic              out_valid_reg, zero_flag_reg, illegal_reg;
  logic [DATA_W-1:0] out_data_reg;

  logic [2:0]        in_op;
  logic [ADDR_W-1:0] in_rd, in_rs, in_rt;
  logic [DATA_W-1:0] in_imm;
  logic              accept;

  logic [ADDR_W-1:0] raddr_a;
  logic [DATA_W-1:0] rdata_a, rdata_b;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  assign in_op  = instr[OP_MSB:OP_LSB];
  assign in_rd  = instr[RD_MSB:RD_LSB];
  assign in_rs  = instr[RS_MSB:RS_LSB];
  assign in_rt  = instr[RT_MSB:RT_LSB];
  assign in_imm = instr[IMM_MSB:IMM_LSB];

  assign instr_ready = rst_n && (state_reg == ST_IDLE);
  assign accept      = instr_valid && instr_ready;

  // Port A serves OUT straight from the incoming word while idle, and the
  // latched rs during EXEC.
  assign raddr_a = (state_reg == ST_EXEC) ? rs_reg : in_rs;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = in_rd;
    rf_wdata = in_imm;
    if (state_reg == ST_EXEC) begin
      rf_we    = 1'b1;
      rf_waddr = rd_reg;
      rf_wdata = alu_result;
    end else if (accept && in_op == OP_LDI) begin
      rf_we = 1'b1;
    end
  end

  alu_regfile #(
    .DATA_W(DATA_W),
    .NREGS (NREGS)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr_a(raddr_a),
    .raddr_b(rt_reg),
    .rdata_a(rdata_a),
    .rdata_b(rdata_b),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata)
  );

  always_comb begin
    alu_a      = '0;
    alu_b      = '0;
    alu_select = SEL_ADD;
    if (state_reg == ST_EXEC) begin
      alu_a      = rdata_a;
      alu_b      = rdata_b;
      alu_select = op_to_sel(op_reg);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      op_reg        <= OP_ADD;
      rd_reg        <= '0;
      rs_reg        <= '0;
      rt_reg        <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      zero_flag_reg <= 1'b0;
      illegal_reg   <= 1'b0;
    end else begin
      illegal_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            case (in_op)
              OP_ADD, OP_SUB, OP_NOT: begin
                op_reg    <= in_op;
                rd_reg    <= in_rd;
                rs_reg    <= in_rs;
                rt_reg    <= in_rt;
                state_reg <= ST_EXEC;
              end
              OP_LDI: ;
              OP_OUT: begin
                out_data_reg  <= rdata_a;
                out_valid_reg <= 1'b1;
                state_reg     <= ST_EMIT;
              end
              default: illegal_reg <= 1'b1;
            endcase
          end
        end
        ST_EXEC: begin
          zero_flag_reg <= alu_zero;
          state_reg     <= ST_IDLE;
        end
        ST_EMIT: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign zero_flag = zero_flag_reg;
  assign illegal   = illegal_reg;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle control block that issues operations to the 8-bit combinational ALU (ADD/SUB/NOT, zero flag) and consumes its result and zero flag.
- Accepts 16-bit instruction words over a valid/ready handshake and decodes them.
- Drives the ALU operand/select inputs from a small internal register file, then writes back the result and zero flag.
- Emits register values on a valid/ready output port. Sits between the instruction source and the ALU datapath.

Parameters:
- DATA_W, 8, datapath width; must equal the ALU operand width.
- NREGS, 4, register-file depth; fixed at 4 because the instruction fields are 2 bits.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  synchronous, active-low reset.
- instr_valid  in  1  instruction word present.
- instr_ready  out  1  block can accept an instruction this cycle.
- instr  in  16  instruction word: [15:13] op, [12:11] rd, [10:9] rs, [8:7] rt, [7:0] imm (imm overlaps rt; only LDI uses imm).
- alu_a  out  DATA_W  ALU operand a.
- alu_b  out  DATA_W  ALU operand b.
- alu_select  out  2  ALU select: 00 add, 01 sub, 10 not.
- alu_result  in  DATA_W  ALU Operation output.
- alu_zero  in  1  ALU zero output.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  DATA_W  emitted register value.
- zero_flag  out  1  zero flag of the last ALU write-back.
- illegal  out  1  one-cycle pulse on acceptance of an undefined opcode.

Behaviour:
- Opcodes:
  - 000 ADD: R[rd] = R[rs] + R[rt]
  - 001 SUB: R[rd] = R[rs] - R[rt]
  - 010 NOT: R[rd] = ~R[rs]
  - 011 LDI: R[rd] = imm
  - 100 OUT: emit R[rs]
  - 101-111: illegal
- Arithmetic wraps modulo 2^DATA_W. There is no carry or overflow output.
- Reset (rst_n low at a clock edge), from any state, including mid-EXEC or mid-EMIT:
  - state goes to IDLE; R0..R3 = 0
  - zero_flag = 0, out_valid = 0, out_data = 0, illegal = 0
  - alu_a = alu_b = 0, alu_select = 00
  - instr_ready = 0 while rst_n is low.
  - A pending output is dropped.
- FSM states IDLE, EXEC, EMIT:
  - IDLE: instr_ready = 1. Acceptance happens on an edge where instr_valid & instr_ready.
    - ALU op: latch op/rd/rs/rt, go to EXEC.
    - LDI: write R[rd] = imm at that same edge, stay in IDLE. zero_flag is unchanged.
    - OUT: load out_data = R[rs], set out_valid = 1, go to EMIT.
    - illegal: pulse illegal for the next cycle, stay in IDLE. No state change.
  - EXEC (exactly one cycle): instr_ready = 0.
    - alu_a = R[rs]; alu_b = R[rt] (NOT also drives R[rt], which the ALU ignores).
    - alu_select is decoded from op.
    - At the end of the cycle: R[rd] = alu_result and zero_flag = alu_zero, then go to IDLE.
  - EMIT: instr_ready = 0; out_valid and out_data are held stable.
    - On an edge with out_ready = 1: clear out_valid, go to IDLE.
    - out_ready high on the first EMIT cycle completes in that cycle.
- Outside EXEC, alu_a = alu_b = 0 and alu_select = 00. alu_a, alu_b and alu_select are decoded combinationally from the latched fields and the state.
- Latency:
  - ALU op accepted at edge N: write-back at edge N+1; next accept possible at edge N+2.
  - LDI: back-to-back accepts every cycle.
  - OUT: minimum 2 cycles between accepts.
- Hazards: none. A write-back completes before the next instruction reads the register file.
  - rd == rs or rd == rt is legal; the old value is used as the operand.
- R0 is a normal writable register.
- instr is ignored when instr_ready = 0. instr_valid may stay high without being consumed.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_ADD..OP_OUT
  - ALU select constants SEL_ADD = 00, SEL_SUB = 01, SEL_NOT = 10
  - state encoding
  - instruction field bit positions
- Natural sub-module: alu_regfile (4 x DATA_W, two combinational read ports, one synchronous write port, synchronous active-low clear).
- The ALU itself is instantiated beside this block, not inside it.

Test Plan:
- Reset mid-EXEC: assert rst_n = 0 during EXEC -> next cycle all regs 0, zero_flag 0, state IDLE, no write-back.
- LDI R1 = 0x05, LDI R2 = 0x03, ADD R3 = R1 + R2, OUT R3 -> out_data 0x08, zero_flag 0.
- ADD wrap: LDI R0 = 0xFF, LDI R1 = 0x01, ADD R2 = R0 + R1 -> R2 = 0x00, zero_flag 1.
- SUB equal operands: R1 = 0x05, R1 - R1 into R1 -> R1 = 0x00, zero_flag 1.
- NOT then illegal:
  - R0 = 0x0F, NOT R3 = ~R0 -> R3 = 0xF0, zero_flag 0.
  - op 111 -> illegal pulses for one cycle; regs and zero_flag unchanged.
- OUT backpressure: out_ready low for 5 cycles -> out_valid and out_data held, instr_ready 0, instr_valid ignored. Completes on the first edge with out_ready high.
